// File: rtl/lives_pkg.sv
// Shared types and defaults for the lives controller.
// The optional debug-switch path is enabled by defining DEBUG_LIVES_EN.
package lives_pkg;

    typedef enum logic [1:0] {
        ALIVE     = 2'd0,
        DYING     = 2'd1,
        INVULN    = 2'd2,
        GAME_OVER = 2'd3
    } lives_state_t;

    localparam int DEF_MAX_LIVES     = 3;
    localparam int DEF_START_LIVES   = 3;
    localparam int DEF_LIVES_W       = 2;
    localparam int DEF_DEATH_FRAMES  = 60;
    localparam int DEF_INVULN_FRAMES = 120;

    // Increment with a ceiling; the count never exceeds max_v.
    function automatic int sat_inc(input int v, input int max_v);
        if (v >= max_v) begin
            return max_v;
        end else begin
            return v + 1;
        end
    endfunction

    // Decrement with a floor at zero; the count never underflows.
    function automatic int sat_dec(input int v);
        if (v <= 0) begin
            return 0;
        end else begin
            return v - 1;
        end
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame-gated counter shared by the DYING and INVULN windows.
// Counts start_of_frame pulses while enabled, saturates at the terminal
// value and flags the frame pulse that brings the count to terminal.
module frame_timer #(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic             start_of_frame,
    input  logic [CNT_W-1:0] terminal,
    output logic             done
);

    logic [CNT_W-1:0] count_r;
    logic             done_s;

    // Done fires on the frame pulse that would make the count equal terminal.
    always_comb begin
        done_s = 1'b0;
        if (enable && start_of_frame && ((count_r + CNT_W'(1)) == terminal)) begin
            done_s = 1'b1;
        end else begin
            done_s = 1'b0;
        end
    end

    // Frame counter: cleared on request, holds at terminal so it never wraps.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable && start_of_frame && (count_r != terminal)) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign done = done_s;

endmodule

// File: rtl/lives_controller.sv
// Player lives bookkeeping and hit -> death -> respawn -> invulnerability
// -> game-over sequencing. Define DEBUG_LIVES_EN to let the dbg_inc /
// dbg_dec switches add or remove a life on their rising edges.
module lives_controller
    import lives_pkg::*;
#(
    parameter int MAX_LIVES     = DEF_MAX_LIVES,
    parameter int START_LIVES   = DEF_START_LIVES,
    parameter int LIVES_W       = DEF_LIVES_W,
    parameter int DEATH_FRAMES  = DEF_DEATH_FRAMES,
    parameter int INVULN_FRAMES = DEF_INVULN_FRAMES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_of_frame,
    input  logic               hit_bomb,
    input  logic               hit_enemy,
    input  logic               bonus_life,
    input  logic               game_restart,
    input  logic               dbg_inc,
    input  logic               dbg_dec,
    output logic [LIVES_W-1:0] lives,
    output logic               player_died,
    output logic               invulnerable,
    output logic               respawn,
    output logic               game_over
);

    localparam int MAX_FRAMES = (DEATH_FRAMES > INVULN_FRAMES) ? DEATH_FRAMES : INVULN_FRAMES;
    localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

    localparam logic [CNT_W-1:0]   DEATH_T  = CNT_W'(DEATH_FRAMES);
    localparam logic [CNT_W-1:0]   INVULN_T = CNT_W'(INVULN_FRAMES);
    localparam logic [LIVES_W-1:0] START_L  = LIVES_W'(START_LIVES);

    lives_state_t       state_r;
    logic [LIVES_W-1:0] lives_r;
    logic               player_died_r;
    logic               invulnerable_r;
    logic               respawn_r;
    logic               game_over_r;

    logic               hit_s;
    logic               dbg_inc_edge_s;
    logic               dbg_dec_edge_s;
    logic               loss_s;
    logic               gain_s;
    logic               timer_en_s;
    logic               timer_clr_s;
    logic               timer_done_s;
    logic [CNT_W-1:0]   timer_term_s;
    logic [LIVES_W-1:0] lives_inc_s;
    logic [LIVES_W-1:0] lives_dec_s;

    assign hit_s = hit_bomb | hit_enemy;

`ifdef DEBUG_LIVES_EN
    logic dbg_inc_r;
    logic dbg_dec_r;

    // Previous switch levels, used to turn held switches into single edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            dbg_inc_r <= 1'b0;
            dbg_dec_r <= 1'b0;
        end else begin
            dbg_inc_r <= dbg_inc;
            dbg_dec_r <= dbg_dec;
        end
    end

    assign dbg_inc_edge_s = dbg_inc & ~dbg_inc_r;
    assign dbg_dec_edge_s = dbg_dec & ~dbg_dec_r;
`else
    logic unused_dbg_s;
    assign unused_dbg_s   = dbg_inc ^ dbg_dec;
    assign dbg_inc_edge_s = 1'b0;
    assign dbg_dec_edge_s = 1'b0;
`endif

    // A debug decrement behaves like a hit; a debug increment like a bonus.
    assign loss_s = hit_s | dbg_dec_edge_s;
    assign gain_s = bonus_life | dbg_inc_edge_s;

    assign lives_inc_s = LIVES_W'(sat_inc(int'(lives_r), MAX_LIVES));
    assign lives_dec_s = LIVES_W'(sat_dec(int'(lives_r)));

    // Timer control: terminal muxed by state, cleared on every state entry.
    always_comb begin
        timer_en_s   = 1'b0;
        timer_term_s = INVULN_T;
        timer_clr_s  = 1'b0;
        case (state_r)
            DYING: begin
                timer_en_s   = 1'b1;
                timer_term_s = DEATH_T;
            end
            INVULN: begin
                timer_en_s   = 1'b1;
                timer_term_s = INVULN_T;
            end
            default: begin
                timer_en_s   = 1'b0;
                timer_term_s = INVULN_T;
            end
        endcase
        if (reset || game_restart) begin
            timer_clr_s = 1'b1;
        end else if ((state_r == ALIVE) && loss_s) begin
            timer_clr_s = 1'b1;
        end else if ((state_r == INVULN) && dbg_dec_edge_s) begin
            timer_clr_s = 1'b1;
        end else if (timer_done_s) begin
            timer_clr_s = 1'b1;
        end else begin
            timer_clr_s = 1'b0;
        end
    end

    frame_timer #(
        .CNT_W(CNT_W)
    ) u_frame_timer (
        .clk           (clk),
        .reset         (reset),
        .clear         (timer_clr_s),
        .enable        (timer_en_s),
        .start_of_frame(start_of_frame),
        .terminal      (timer_term_s),
        .done          (timer_done_s)
    );

    // Lives FSM with registered status flags; restart outranks every request.
    always_ff @(posedge clk) begin
        if (reset || game_restart) begin
            state_r        <= ALIVE;
            lives_r        <= START_L;
            player_died_r  <= 1'b0;
            invulnerable_r <= 1'b0;
            respawn_r      <= 1'b0;
            game_over_r    <= 1'b0;
        end else begin
            respawn_r <= 1'b0;
            case (state_r)
                ALIVE: begin
                    if (loss_s) begin
                        lives_r       <= lives_dec_s;
                        state_r       <= DYING;
                        player_died_r <= 1'b1;
                    end else if (gain_s) begin
                        lives_r <= lives_inc_s;
                    end else begin
                        lives_r <= lives_r;
                    end
                end
                DYING: begin
                    if (timer_done_s) begin
                        player_died_r <= 1'b0;
                        if (lives_r == {LIVES_W{1'b0}}) begin
                            state_r     <= GAME_OVER;
                            game_over_r <= 1'b1;
                        end else begin
                            state_r        <= INVULN;
                            invulnerable_r <= 1'b1;
                            respawn_r      <= 1'b1;
                        end
                    end else begin
                        state_r <= DYING;
                    end
                end
                INVULN: begin
                    if (dbg_dec_edge_s) begin
                        lives_r        <= lives_dec_s;
                        state_r        <= DYING;
                        invulnerable_r <= 1'b0;
                        player_died_r  <= 1'b1;
                    end else begin
                        if (gain_s) begin
                            lives_r <= lives_inc_s;
                        end else begin
                            lives_r <= lives_r;
                        end
                        if (timer_done_s) begin
                            state_r        <= ALIVE;
                            invulnerable_r <= 1'b0;
                        end else begin
                            state_r <= INVULN;
                        end
                    end
                end
                GAME_OVER: begin
                    lives_r     <= {LIVES_W{1'b0}};
                    game_over_r <= 1'b1;
                end
                default: begin
                    state_r        <= ALIVE;
                    lives_r        <= START_L;
                    player_died_r  <= 1'b0;
                    invulnerable_r <= 1'b0;
                    game_over_r    <= 1'b0;
                end
            endcase
        end
    end

    assign lives        = lives_r;
    assign player_died  = player_died_r;
    assign invulnerable = invulnerable_r;
    assign respawn      = respawn_r;
    assign game_over    = game_over_r;

endmodule

// File: tb/tb_lives_controller.sv
// Self-checking bench for lives_controller: directed scenarios followed by
// randomized traffic, every cycle compared against a behavioural model.
module tb_lives_controller;

    localparam int MAXL   = 3;
    localparam int STARTL = 3;
    localparam int DEATHF = 60;
    localparam int INVF   = 120;

    localparam int M_ALIVE = 0;
    localparam int M_DYING = 1;
    localparam int M_INV   = 2;
    localparam int M_GO    = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start_of_frame = 1'b0;
    logic       hit_bomb = 1'b0;
    logic       hit_enemy = 1'b0;
    logic       bonus_life = 1'b0;
    logic       game_restart = 1'b0;
    logic       dbg_inc = 1'b0;
    logic       dbg_dec = 1'b0;
    logic [1:0] lives;
    logic       player_died;
    logic       invulnerable;
    logic       respawn;
    logic       game_over;

    int checks_cnt = 0;
    int errors_cnt = 0;

    // Reference model state
    int mode_m   = M_ALIVE;
    int lives_m  = STARTL;
    int frames_m = 0;
    bit respawn_m = 1'b0;
    bit prev_inc_m = 1'b0;
    bit prev_dec_m = 1'b0;

    always #5 clk = ~clk;

    lives_controller dut (
        .clk           (clk),
        .reset         (reset),
        .start_of_frame(start_of_frame),
        .hit_bomb      (hit_bomb),
        .hit_enemy     (hit_enemy),
        .bonus_life    (bonus_life),
        .game_restart  (game_restart),
        .dbg_inc       (dbg_inc),
        .dbg_dec       (dbg_dec),
        .lives         (lives),
        .player_died   (player_died),
        .invulnerable  (invulnerable),
        .respawn       (respawn),
        .game_over     (game_over)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock of the game rules, written as plain arithmetic on the model.
    task automatic model_step(input bit rst, input bit sof, input bit hb, input bit he,
                              input bit bl, input bit gr, input bit di, input bit dd);
        bit inc_e;
        bit dec_e;
        bit hit;
        inc_e = 1'b0;
        dec_e = 1'b0;
`ifdef DEBUG_LIVES_EN
        inc_e = di && !prev_inc_m;
        dec_e = dd && !prev_dec_m;
`endif
        prev_inc_m = rst ? 1'b0 : di;
        prev_dec_m = rst ? 1'b0 : dd;
        respawn_m  = 1'b0;
        hit        = hb | he;
        if (rst || gr) begin
            mode_m   = M_ALIVE;
            lives_m  = STARTL;
            frames_m = 0;
            return;
        end
        case (mode_m)
            M_ALIVE: begin
                if (hit || dec_e) begin
                    lives_m  = lives_m - 1;
                    frames_m = 0;
                    mode_m   = M_DYING;
                end else if (bl || inc_e) begin
                    lives_m = (lives_m + 1 > MAXL) ? MAXL : lives_m + 1;
                end
            end
            M_DYING: begin
                if (sof) begin
                    frames_m++;
                    if (frames_m == DEATHF) begin
                        frames_m = 0;
                        if (lives_m == 0) begin
                            mode_m = M_GO;
                        end else begin
                            mode_m    = M_INV;
                            respawn_m = 1'b1;
                        end
                    end
                end
            end
            M_INV: begin
                if (dec_e) begin
                    lives_m  = (lives_m > 0) ? lives_m - 1 : 0;
                    frames_m = 0;
                    mode_m   = M_DYING;
                end else begin
                    if (bl || inc_e) begin
                        lives_m = (lives_m + 1 > MAXL) ? MAXL : lives_m + 1;
                    end
                    if (sof) begin
                        frames_m++;
                        if (frames_m == INVF) begin
                            frames_m = 0;
                            mode_m   = M_ALIVE;
                        end
                    end
                end
            end
            default: begin
                lives_m = 0;
            end
        endcase
    endtask

    // Drive one cycle of inputs, advance the model on the edge, compare on the falling edge.
    task automatic tick(input bit rst, input bit sof, input bit hb, input bit he,
                        input bit bl, input bit gr);
        reset          = rst;
        start_of_frame = sof;
        hit_bomb       = hb;
        hit_enemy      = he;
        bonus_life     = bl;
        game_restart   = gr;
        @(posedge clk);
        model_step(rst, sof, hb, he, bl, gr, dbg_inc, dbg_dec);
        @(negedge clk);
        check_val("lives", 32'(lives), 32'(lives_m));
        check_val("player_died", 32'(player_died), 32'(mode_m == M_DYING));
        check_val("invulnerable", 32'(invulnerable), 32'(mode_m == M_INV));
        check_val("game_over", 32'(game_over), 32'(mode_m == M_GO));
        check_val("respawn", 32'(respawn), 32'(respawn_m));
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            idle();
        end
    endtask

    initial begin
        @(negedge clk);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        frames(5);

        // Hit from full lives, frame-by-frame through death and invulnerability
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        frames(10);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        frames(DEATHF - 10);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        frames(INVF);

        // Hit and bonus together at lives=2: the hit wins
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        frames(DEATHF + INVF);

        // Last life lost, game over, requests ignored, restart
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        frames(DEATHF + 3);
        tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        idle();

        // Bonus saturation during invulnerability
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        frames(DEATHF);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        frames(INVF);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Debug switches: held decrement, then two increment toggles
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        dbg_dec = 1'b1;
        for (int i = 0; i < 10; i++) idle();
        dbg_dec = 1'b0;
        frames(DEATHF + INVF);
        for (int i = 0; i < 4; i++) begin
            dbg_inc = ~dbg_inc;
            idle();
        end

        // Randomized traffic
        for (int i = 0; i < 8000; i++) begin
            if ($urandom_range(49, 0) == 0) dbg_inc = ~dbg_inc;
            if ($urandom_range(79, 0) == 0) dbg_dec = ~dbg_dec;
            tick(1'b0,
                 1'($urandom_range(1, 0)),
                 1'($urandom_range(39, 0) == 0),
                 1'($urandom_range(39, 0) == 0),
                 1'($urandom_range(14, 0) == 0),
                 1'($urandom_range(599, 0) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
